cpu_ctrl_fsm_p: RTL and testbench



---
 rtl/cpu_ctrl_pkg.sv | 47 ++++
 rtl/mem_wait_ctr.sv | 37 +++
 rtl/cpu_ctrl_fsm_p.sv | 213 +++++++++++++++++++++
 tb/tb_cpu_ctrl_fsm_p.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// cpu_ctrl_pkg
// Shared types and constants for the parametrised CPU control unit.
//   state_t  : control FSM states. The encodings are fixed because they are
//              visible on the CurrentState/NextState debug ports.
//   opcode_t : instruction opcodes held in the top four bits of the IR.
//   RF_S_*   : register-file write mux selects.
//   ALU_*    : ALU operation selects.
// ---------------------------------------------------------------------------
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        INIT    = 4'd0,
        FETCH   = 4'd1,
        DECODE  = 4'd2,
        LOAD_RD = 4'd3,
        LOAD_WB = 4'd4,
        STORE   = 4'd5,
        ALU     = 4'd6,
        LOADI   = 4'd7,
        BRANCH  = 4'd8,
        HALT    = 4'd9
    } state_t;

    // Opcode names carry an OP_ prefix so they do not collide with the
    // state names that share the same words (STORE, LOADI, HALT).
    typedef enum logic [3:0] {
        OP_NOOP  = 4'd0,
        OP_STORE = 4'd1,
        OP_LOAD  = 4'd2,
        OP_ADD   = 4'd3,
        OP_SUB   = 4'd4,
        OP_HALT  = 4'd5,
        OP_LOADI = 4'd6,
        OP_JMP   = 4'd7,
        OP_JZ    = 4'd8
    } opcode_t;

    localparam logic [1:0] RF_S_ALU = 2'b00;
    localparam logic [1:0] RF_S_RAM = 2'b01;
    localparam logic [1:0] RF_S_IMM = 2'b10;

    localparam logic [2:0] ALU_PASS = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;

endpackage

// File: rtl/mem_wait_ctr.sv
// ---------------------------------------------------------------------------
// mem_wait_ctr
// Loadable 4-bit downcounter used to stretch the fetch and load states over
// the memory read latency. It stops at zero rather than wrapping.
//   clk      in  system clock
//   Reset    in  synchronous, active-high reset (count -> 0)
//   load     in  load count from load_val (takes priority over dec)
//   dec      in  decrement count when non-zero
//   load_val in  [3:0] value to load
//   zero     out count == 0
// ---------------------------------------------------------------------------
module mem_wait_ctr (
    input  logic       clk,
    input  logic       Reset,
    input  logic       load,
    input  logic       dec,
    input  logic [3:0] load_val,
    output logic       zero
);

    logic [3:0] count;

    // Count register: reset clears it, a load restarts the wait, otherwise it
    // walks down towards zero and parks there until the next load.
    always_ff @(posedge clk) begin
        if (Reset) begin
            count <= 4'd0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != 4'd0)) begin
            count <= count - 4'd1;
        end
    end

    assign zero = (count == 4'd0);

endmodule

// File: rtl/cpu_ctrl_fsm_p.sv
// ---------------------------------------------------------------------------
// cpu_ctrl_fsm_p
// Parametrised control unit for the single-cycle-datapath CPU. Fetches and
// decodes the IR, then sequences PC, IR, data RAM, register file and ALU.
// Supports NOOP, STORE, LOAD, ADD, SUB, HALT, LOADI, JMP and JZ, with a
// configurable memory read latency for fetch and LOAD.
// Parameters:
//   RF_AW   register-file address width (D_AW = 2*RF_AW, IR_W = 4+3*RF_AW)
//   MEM_LAT memory read latency in cycles, legal range 1..15
// Ports:
//   clk, Reset                        clock, synchronous active-high reset
//   IR [IR_W], Rp_zero                instruction word, RF port A == 0
//   PC_Clr, PC_Up, PC_Ld, PC_Addr     program counter control / jump target
//   IR_Ld                             load IR from instruction memory
//   D_Addr, D_wr                      data RAM address / write enable
//   RF_s, RF_Imm                      RF write mux select / LOADI immediate
//   RF_W_addr, RF_Ra_addr, RF_Rb_addr register-file addresses
//   RF_W_en                           RF write enable
//   ALU_s                             ALU operation select
//   Halted                            high while in HALT
//   CurrentState, NextState           debug view of the FSM
// ---------------------------------------------------------------------------
module cpu_ctrl_fsm_p
    import cpu_ctrl_pkg::*;
#(
    parameter int RF_AW   = 4,
    parameter int MEM_LAT = 1,
    localparam int D_AW   = 2 * RF_AW,
    localparam int IR_W   = 4 + 3 * RF_AW
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic [IR_W-1:0]   IR,
    input  logic              Rp_zero,
    output logic              PC_Clr,
    output logic              PC_Up,
    output logic              PC_Ld,
    output logic [D_AW-1:0]   PC_Addr,
    output logic              IR_Ld,
    output logic [D_AW-1:0]   D_Addr,
    output logic              D_wr,
    output logic [1:0]        RF_s,
    output logic [D_AW-1:0]   RF_Imm,
    output logic [RF_AW-1:0]  RF_W_addr,
    output logic [RF_AW-1:0]  RF_Ra_addr,
    output logic [RF_AW-1:0]  RF_Rb_addr,
    output logic              RF_W_en,
    output logic [2:0]        ALU_s,
    output logic              Halted,
    output logic [3:0]        CurrentState,
    output logic [3:0]        NextState
);

    // A latency of N cycles means the wait counter starts at N-1, so a
    // latency of 1 gives single-cycle FETCH and LOAD_RD.
    localparam logic [3:0] WAIT_LOAD = 4'(MEM_LAT - 1);

    state_t state;
    state_t next_state;

    logic [3:0]       op;
    logic [RF_AW-1:0] fld_a;
    logic [RF_AW-1:0] fld_b;
    logic [RF_AW-1:0] fld_d;
    logic [D_AW-1:0]  addr_lo;
    logic [D_AW-1:0]  addr_hi;

    logic wait_load;
    logic wait_dec;
    logic wait_zero;

    assign op      = IR[IR_W-1 -: 4];
    assign fld_a   = IR[3*RF_AW-1 -: RF_AW];
    assign fld_b   = IR[2*RF_AW-1 -: RF_AW];
    assign fld_d   = IR[RF_AW-1:0];
    assign addr_lo = IR[D_AW-1:0];
    assign addr_hi = IR[3*RF_AW-1 -: D_AW];

    // The wait counter is reloaded only when the FSM enters FETCH or LOAD_RD
    // from another state, and it counts down while the FSM sits in them.
    assign wait_load = (next_state != state) &&
                       ((next_state == FETCH) || (next_state == LOAD_RD));
    assign wait_dec  = (state == FETCH) || (state == LOAD_RD);

    mem_wait_ctr u_wait (
        .clk      (clk),
        .Reset    (Reset),
        .load     (wait_load),
        .dec      (wait_dec),
        .load_val (WAIT_LOAD),
        .zero     (wait_zero)
    );

    // State register. Reset wins over every transition, so it also pulls the
    // FSM out of HALT and out of any pending memory wait.
    always_ff @(posedge clk) begin
        if (Reset) begin
            state <= INIT;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and output decode. Every output is a pure function of the
    // current state, the IR and Rp_zero, and defaults to zero so that only
    // the state that owns a signal ever raises it. Unused encodings fall into
    // the default branch and return to INIT with everything quiet.
    always_comb begin
        next_state = INIT;
        PC_Clr     = 1'b0;
        PC_Up      = 1'b0;
        PC_Ld      = 1'b0;
        PC_Addr    = '0;
        IR_Ld      = 1'b0;
        D_Addr     = '0;
        D_wr       = 1'b0;
        RF_s       = RF_S_ALU;
        RF_Imm     = '0;
        RF_W_addr  = '0;
        RF_Ra_addr = '0;
        RF_Rb_addr = '0;
        RF_W_en    = 1'b0;
        ALU_s      = ALU_PASS;
        Halted     = 1'b0;

        case (state)
            INIT: begin
                PC_Clr     = 1'b1;
                next_state = FETCH;
            end
            FETCH: begin
                if (wait_zero) begin
                    IR_Ld      = 1'b1;
                    PC_Up      = 1'b1;
                    next_state = DECODE;
                end else begin
                    next_state = FETCH;
                end
            end
            DECODE: begin
                case (op)
                    OP_STORE:       next_state = STORE;
                    OP_LOAD:        next_state = LOAD_RD;
                    OP_ADD, OP_SUB: next_state = ALU;
                    OP_HALT:        next_state = HALT;
                    OP_LOADI:       next_state = LOADI;
                    OP_JMP, OP_JZ:  next_state = BRANCH;
                    default:        next_state = FETCH;
                endcase
            end
            LOAD_RD: begin
                D_Addr     = addr_hi;
                RF_s       = RF_S_RAM;
                RF_W_addr  = fld_d;
                next_state = wait_zero ? LOAD_WB : LOAD_RD;
            end
            LOAD_WB: begin
                D_Addr     = addr_hi;
                RF_s       = RF_S_RAM;
                RF_W_addr  = fld_d;
                RF_W_en    = 1'b1;
                next_state = FETCH;
            end
            STORE: begin
                D_Addr     = addr_lo;
                RF_Ra_addr = fld_a;
                D_wr       = 1'b1;
                next_state = FETCH;
            end
            ALU: begin
                RF_Ra_addr = fld_a;
                RF_Rb_addr = fld_b;
                RF_W_addr  = fld_d;
                RF_W_en    = 1'b1;
                RF_s       = RF_S_ALU;
                if (op == OP_ADD) begin
                    ALU_s = ALU_ADD;
                end else if (op == OP_SUB) begin
                    ALU_s = ALU_SUB;
                end
                next_state = FETCH;
            end
            LOADI: begin
                RF_Imm     = addr_lo;
                RF_s       = RF_S_IMM;
                RF_W_addr  = fld_a;
                RF_W_en    = 1'b1;
                next_state = FETCH;
            end
            BRANCH: begin
                PC_Addr    = addr_lo;
                RF_Ra_addr = fld_a;
                // JZ looks at Rp_zero in this same cycle, while port A is
                // addressed by field A.
                if ((op == OP_JMP) || ((op == OP_JZ) && Rp_zero)) begin
                    PC_Ld = 1'b1;
                end
                next_state = FETCH;
            end
            HALT: begin
                Halted     = 1'b1;
                next_state = HALT;
            end
            default: begin
                next_state = INIT;
            end
        endcase
    end

    assign CurrentState = state;
    assign NextState    = next_state;

endmodule

// File: tb/tb_cpu_ctrl_fsm_p.sv
// ---------------------------------------------------------------------------
// tb_cpu_ctrl_fsm_p
// Directed bench for cpu_ctrl_fsm_p. Two instances share IR and Rp_zero:
// u_dut1 runs with MEM_LAT=1, u_dut3 with MEM_LAT=3. Each has its own reset
// so one can be parked in reset while the other is exercised.
// ---------------------------------------------------------------------------
module tb_cpu_ctrl_fsm_p;

    logic        clk;
    logic        reset1;
    logic        reset3;
    logic [15:0] ir;
    logic        rp_zero;

    logic       pc_clr1, pc_up1, pc_ld1, ir_ld1, d_wr1, rf_w_en1, halted1;
    logic [7:0] pc_addr1, d_addr1, rf_imm1;
    logic [1:0] rf_s1;
    logic [3:0] rf_w_addr1, rf_ra_addr1, rf_rb_addr1;
    logic [2:0] alu_s1;
    logic [3:0] cur_state1, nxt_state1;

    logic       pc_clr3, pc_up3, pc_ld3, ir_ld3, d_wr3, rf_w_en3, halted3;
    logic [7:0] pc_addr3, d_addr3, rf_imm3;
    logic [1:0] rf_s3;
    logic [3:0] rf_w_addr3, rf_ra_addr3, rf_rb_addr3;
    logic [2:0] alu_s3;
    logic [3:0] cur_state3, nxt_state3;

    int vectors;
    int miscompares;

    cpu_ctrl_fsm_p #(.RF_AW(4), .MEM_LAT(1)) u_dut1 (
        .clk          (clk),
        .Reset        (reset1),
        .IR           (ir),
        .Rp_zero      (rp_zero),
        .PC_Clr       (pc_clr1),
        .PC_Up        (pc_up1),
        .PC_Ld        (pc_ld1),
        .PC_Addr      (pc_addr1),
        .IR_Ld        (ir_ld1),
        .D_Addr       (d_addr1),
        .D_wr         (d_wr1),
        .RF_s         (rf_s1),
        .RF_Imm       (rf_imm1),
        .RF_W_addr    (rf_w_addr1),
        .RF_Ra_addr   (rf_ra_addr1),
        .RF_Rb_addr   (rf_rb_addr1),
        .RF_W_en      (rf_w_en1),
        .ALU_s        (alu_s1),
        .Halted       (halted1),
        .CurrentState (cur_state1),
        .NextState    (nxt_state1)
    );

    cpu_ctrl_fsm_p #(.RF_AW(4), .MEM_LAT(3)) u_dut3 (
        .clk          (clk),
        .Reset        (reset3),
        .IR           (ir),
        .Rp_zero      (rp_zero),
        .PC_Clr       (pc_clr3),
        .PC_Up        (pc_up3),
        .PC_Ld        (pc_ld3),
        .PC_Addr      (pc_addr3),
        .IR_Ld        (ir_ld3),
        .D_Addr       (d_addr3),
        .D_wr         (d_wr3),
        .RF_s         (rf_s3),
        .RF_Imm       (rf_imm3),
        .RF_W_addr    (rf_w_addr3),
        .RF_Ra_addr   (rf_ra_addr3),
        .RF_Rb_addr   (rf_rb_addr3),
        .RF_W_en      (rf_w_en3),
        .ALU_s        (alu_s3),
        .Halted       (halted3),
        .CurrentState (cur_state3),
        .NextState    (nxt_state3)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every vector and reports mismatches.
    task automatic checkOutput(input string tag, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle 1 ns past the edge before anyone looks.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    // Drive a new IR and let the combinational decode settle.
    task automatic setIr(input logic [15:0] value);
        ir = value;
        #1;
    endtask

    // Run u_dut1 from FETCH into DECODE with the given instruction, checking
    // the fetch strobe and the decoded next state on the way.
    task automatic fetchDecode1(input string name, input logic [15:0] value, input int exp_next);
        checkOutput({name, " fetch state"}, cur_state1, 1);
        checkOutput({name, " fetch IR_Ld/PC_Up"}, {ir_ld1, pc_up1, pc_ld1}, 3'b110);
        applyStimulus();
        setIr(value);
        checkOutput({name, " decode state"}, cur_state1, 2);
        checkOutput({name, " decode next"}, nxt_state1, exp_next);
        applyStimulus();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset1      = 1'b1;
        reset3      = 1'b1;
        ir          = 16'h0000;
        rp_zero     = 1'b0;

        // ---------------- MEM_LAT = 1 instance ----------------
        applyStimulus();
        applyStimulus();
        checkOutput("reset state", cur_state1, 0);
        checkOutput("reset PC_Clr", pc_clr1, 1);
        checkOutput("reset quiet", {pc_up1, pc_ld1, ir_ld1, d_wr1, rf_w_en1, halted1}, 0);

        reset1 = 1'b0;
        applyStimulus();
        checkOutput("first fetch state", cur_state1, 1);
        checkOutput("first fetch IR_Ld/PC_Up/PC_Clr", {ir_ld1, pc_up1, pc_clr1}, 3'b110);
        applyStimulus();
        checkOutput("first decode state", cur_state1, 2);
        checkOutput("decode quiet",
                    {pc_clr1, pc_up1, pc_ld1, ir_ld1, d_wr1, rf_w_en1, halted1, d_addr1, alu_s1}, 0);
        checkOutput("NOOP next", nxt_state1, 1);
        applyStimulus();

        // ADD r4 = r2 + r3
        fetchDecode1("ADD", 16'h3234, 6);
        checkOutput("ADD state", cur_state1, 6);
        checkOutput("ADD Ra/Rb/Wa", {rf_ra_addr1, rf_rb_addr1, rf_w_addr1}, 12'h234);
        checkOutput("ADD ALU_s", alu_s1, 3'b001);
        checkOutput("ADD W_en/RF_s", {rf_w_en1, rf_s1}, 3'b100);
        applyStimulus();
        checkOutput("after ADD W_en", rf_w_en1, 0);

        // SUB r7 = r5 - r6
        fetchDecode1("SUB", 16'h4567, 6);
        checkOutput("SUB ALU_s", alu_s1, 3'b010);
        checkOutput("SUB Ra/Rb/Wa", {rf_ra_addr1, rf_rb_addr1, rf_w_addr1}, 12'h567);
        applyStimulus();

        // JZ r2, 0x42: taken then not taken within the same BRANCH cycle
        rp_zero = 1'b1;
        fetchDecode1("JZ", 16'h8242, 8);
        checkOutput("JZ taken PC_Ld/PC_Up", {pc_ld1, pc_up1}, 2'b10);
        checkOutput("JZ PC_Addr", pc_addr1, 8'h42);
        checkOutput("JZ Ra", rf_ra_addr1, 2);
        rp_zero = 1'b0;
        #1;
        checkOutput("JZ not taken PC_Ld", pc_ld1, 0);
        applyStimulus();

        // JMP 0x80 ignores Rp_zero
        fetchDecode1("JMP", 16'h7080, 8);
        checkOutput("JMP PC_Ld", pc_ld1, 1);
        checkOutput("JMP PC_Addr", pc_addr1, 8'h80);
        applyStimulus();

        // STORE rA -> [0x37]
        fetchDecode1("STORE", 16'h1A37, 5);
        checkOutput("STORE D_wr/D_Addr", {d_wr1, d_addr1}, 9'h137);
        checkOutput("STORE Ra", rf_ra_addr1, 4'hA);
        applyStimulus();
        checkOutput("after STORE D_wr", d_wr1, 0);

        // LOADI rA = 0x5C
        fetchDecode1("LOADI", 16'h6A5C, 7);
        checkOutput("LOADI RF_Imm", rf_imm1, 8'h5C);
        checkOutput("LOADI RF_s/W_en/Wa", {rf_s1, rf_w_en1, rf_w_addr1}, 7'b10_1_1010);
        applyStimulus();

        // Illegal opcode behaves like NOOP
        fetchDecode1("ILLEGAL", 16'hF000, 1);
        checkOutput("ILLEGAL back to fetch", cur_state1, 1);
        checkOutput("ILLEGAL no writes", {d_wr1, rf_w_en1, pc_ld1}, 0);

        // HALT holds for more than ten cycles, then reset releases it
        fetchDecode1("HALT", 16'h5000, 9);
        for (int i = 0; i < 11; i++) begin
            checkOutput($sformatf("HALT hold %0d", i), {halted1, cur_state1}, 5'h19);
            applyStimulus();
        end
        reset1 = 1'b1;
        applyStimulus();
        checkOutput("HALT reset state", cur_state1, 0);
        checkOutput("HALT reset Halted/PC_Clr", {halted1, pc_clr1}, 2'b01);

        // ---------------- MEM_LAT = 3 instance ----------------
        ir     = 16'h0000;
        reset3 = 1'b0;
        applyStimulus();
        checkOutput("L3 fetch wait 1", {cur_state3, ir_ld3, pc_up3}, 6'b0001_00);
        applyStimulus();
        checkOutput("L3 fetch wait 2", {cur_state3, ir_ld3, pc_up3}, 6'b0001_00);
        applyStimulus();
        checkOutput("L3 fetch done", {cur_state3, ir_ld3, pc_up3}, 6'b0001_11);
        applyStimulus();
        setIr(16'h2153);
        checkOutput("L3 LOAD decode next", nxt_state3, 3);
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            checkOutput($sformatf("L3 LOAD_RD %0d state", i), cur_state3, 3);
            checkOutput($sformatf("L3 LOAD_RD %0d D_Addr/Wa/W_en", i),
                        {d_addr3, rf_w_addr3, rf_w_en3}, {8'h15, 4'h3, 1'b0});
        end
        applyStimulus();
        checkOutput("L3 LOAD_WB state", cur_state3, 4);
        checkOutput("L3 LOAD_WB W_en/RF_s/D_Addr", {rf_w_en3, rf_s3, d_addr3}, {1'b1, 2'b01, 8'h15});
        applyStimulus();
        checkOutput("L3 after LOAD state/W_en", {cur_state3, rf_w_en3}, 5'b0001_0);

        // Second LOAD interrupted by reset on its second LOAD_RD cycle
        applyStimulus();
        applyStimulus();
        checkOutput("L3 refetch IR_Ld", ir_ld3, 1);
        applyStimulus();
        applyStimulus();
        checkOutput("L3 LOAD_RD again", cur_state3, 3);
        applyStimulus();
        checkOutput("L3 LOAD_RD 2nd cycle", cur_state3, 3);
        reset3 = 1'b1;
        applyStimulus();
        checkOutput("L3 reset mid-load state", cur_state3, 0);
        checkOutput("L3 reset mid-load D_Addr/W_en", {d_addr3, rf_w_en3}, 0);
        checkOutput("L3 reset mid-load PC_Clr", pc_clr3, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
